// File: rtl/lfsr_req_sched_pkg.sv
// Shared types and helpers for the LFSR request scheduler.
package lfsr_req_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_WARMUP = 3'd2,
    ST_READY  = 3'd3,
    ST_STEP   = 3'd4
  } state_e;

  localparam int WORD_CNT_W = 16;

  // Minimum one bit so that degenerate counters still have a legal width.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/lfsr_req_sched_arb.sv
// Combinational round-robin arbiter: first set request at or above ptr, with wrap.
module rr_arbiter
  import lfsr_req_sched_pkg::*;
#(
  parameter int N_REQ = 4,
  localparam int PTR_W = cnt_w(N_REQ)
) (
  input  logic             en,
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [PTR_W-1:0] winner,
  output logic             found
);

  int idx;

  always_comb begin
    gnt    = '0;
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = int'(ptr) + i;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (en && !found && req[idx]) begin
        found    = 1'b1;
        winner   = PTR_W'(idx);
        gnt[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/lfsr_req_sched.sv
// Sequences seed load and warm-up of an attached LFSR, then shares its words
// between requesters round-robin, stepping the LFSR per delivered word.
module lfsr_req_sched
  import lfsr_req_sched_pkg::*;
#(
  parameter int N_REQ         = 4,
  parameter int LFSR_DW       = 8,
  parameter int WARMUP_CYC    = 16,
  parameter int STEP_PER_WORD = 1
) (
  input  logic                  func_clk,
  input  logic                  func_rst_n,
  input  logic                  cfg_en,
  input  logic                  cfg_reseed,
  input  logic [LFSR_DW-1:0]    cfg_seed,
  input  logic [N_REQ-1:0]      req,
  output logic [N_REQ-1:0]      gnt,
  output logic [LFSR_DW-1:0]    rnd_data,
  output logic                  busy,
  output logic [WORD_CNT_W-1:0] word_cnt,
  output logic                  lfsr_load,
  output logic                  lfsr_start,
  output logic [LFSR_DW-1:0]    lfsr_seed,
  input  logic [LFSR_DW-1:0]    lfsr_out
);

  localparam int PTR_W  = cnt_w(N_REQ);
  localparam int WARM_W = cnt_w(WARMUP_CYC + 1);
  localparam int STEP_W = cnt_w(STEP_PER_WORD + 1);
  localparam logic [WARM_W-1:0] WARM_RELOAD = WARM_W'(WARMUP_CYC);
  localparam logic [STEP_W-1:0] STEP_RELOAD = STEP_W'(STEP_PER_WORD - 1);
  localparam logic [PTR_W-1:0]  PTR_LAST    = PTR_W'(N_REQ - 1);

  state_e                state_q, state_d;
  logic [PTR_W-1:0]      ptr_q, ptr_d;
  logic [WARM_W-1:0]     warm_q, warm_d;
  logic [STEP_W-1:0]     step_q, step_d;
  logic [WORD_CNT_W-1:0] word_cnt_q, word_cnt_d;
  logic [LFSR_DW-1:0]    seed_q, seed_d;

  logic             arb_en;
  logic             arb_found;
  logic [PTR_W-1:0] arb_winner;

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .en     (arb_en),
    .req    (req),
    .ptr    (ptr_q),
    .gnt    (gnt),
    .winner (arb_winner),
    .found  (arb_found)
  );

  always_ff @(posedge func_clk or negedge func_rst_n) begin
    if (!func_rst_n) begin
      state_q    <= ST_IDLE;
      ptr_q      <= '0;
      warm_q     <= '0;
      step_q     <= '0;
      word_cnt_q <= '0;
      seed_q     <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      warm_q     <= warm_d;
      step_q     <= step_d;
      word_cnt_q <= word_cnt_d;
      seed_q     <= seed_d;
    end
  end

  // Disable beats reseed, and reseed beats any grant or step in the same cycle.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    warm_d     = warm_q;
    step_d     = step_q;
    word_cnt_d = word_cnt_q;
    seed_d     = seed_q;
    arb_en     = 1'b0;
    lfsr_start = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cfg_en) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        seed_d = cfg_seed;
        if (!cfg_en) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_WARMUP;
          warm_d  = WARM_RELOAD;
        end
      end
      ST_WARMUP: begin
        if (!cfg_en) begin
          state_d = ST_IDLE;
        end else if (cfg_reseed) begin
          state_d = ST_LOAD;
        end else begin
          lfsr_start = 1'b1;
          warm_d     = warm_q - WARM_W'(1);
          if (warm_q <= WARM_W'(1)) state_d = ST_READY;
        end
      end
      ST_READY: begin
        if (!cfg_en) begin
          state_d = ST_IDLE;
        end else if (cfg_reseed) begin
          state_d = ST_LOAD;
        end else begin
          arb_en = 1'b1;
          if (arb_found) begin
            lfsr_start = 1'b1;
            word_cnt_d = word_cnt_q + WORD_CNT_W'(1);
            ptr_d      = (arb_winner == PTR_LAST) ? '0 : arb_winner + PTR_W'(1);
            if (STEP_PER_WORD > 1) begin
              state_d = ST_STEP;
              step_d  = STEP_RELOAD;
            end
          end
        end
      end
      ST_STEP: begin
        if (!cfg_en) begin
          state_d = ST_IDLE;
        end else if (cfg_reseed) begin
          state_d = ST_LOAD;
        end else begin
          lfsr_start = 1'b1;
          step_d     = step_q - STEP_W'(1);
          if (step_q <= STEP_W'(1)) state_d = ST_READY;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign lfsr_load = (state_q == ST_LOAD);
  assign lfsr_seed = (state_q == ST_LOAD) ? cfg_seed : seed_q;
  assign busy      = (state_q != ST_READY);
  assign word_cnt  = word_cnt_q;
  assign rnd_data  = lfsr_out;

endmodule
